// File: rtl/sp_ram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port RAM with one-cycle read latency.
// Optional instruction starvation guard: define SP_RAM_ARB_STARVE_GUARD_EN.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STALL_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e owner;
  logic   force_instr;

`ifdef SP_RAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STALL_MAX + 1);

  logic [CNT_W-1:0] stall_cnt;

  assign force_instr = (stall_cnt == CNT_W'(STALL_MAX));

  // Counts consecutive denied instruction cycles; saturates so instr keeps priority until granted.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      stall_cnt <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      stall_cnt <= '0;
    end else if (!force_instr) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // No guard: data always wins a conflict (STALL_MAX only matters with the guard).
  assign force_instr = (STALL_MAX < 0);
`endif

  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (rstn_i) begin
      if (instr_req_i && (!data_req_i || force_instr)) begin
        instr_gnt_o = 1'b1;
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    ram_en_o    = instr_gnt_o | data_gnt_o;
    ram_addr_o  = instr_addr_i;
    ram_we_o    = 1'b0;
    ram_be_o    = '1;
    ram_wdata_o = '0;
    if (data_gnt_o) begin
      ram_addr_o  = data_addr_i;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_wdata_o = data_wdata_i;
    end
  end

  // Owner records who used the RAM this cycle so the response can be steered next cycle.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      owner <= OWN_NONE;
    end else if (data_gnt_o) begin
      owner <= OWN_DATA;
    end else if (instr_gnt_o) begin
      owner <= OWN_INSTR;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign instr_rvalid_o = rstn_i && (owner == OWN_INSTR);
  assign data_rvalid_o  = rstn_i && (owner == OWN_DATA);
  assign instr_rdata_o  = ram_rdata_i;
  assign data_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed plus randomized bench for sp_ram_arbiter with a RAM emulator and a transaction-level model.
// Build with SP_RAM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_sp_ram_arbiter;

  localparam int AW        = 16;
  localparam int DW        = 32;
  localparam int STALL_MAX = 4;
`ifdef SP_RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          rstn_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  int vectors;
  int miscompares;

  // Reference model state: expected memory contents and responses owed next cycle.
  logic [DW-1:0] shadow [256];
  logic          pend_i;
  logic          pend_d;
  logic          pend_dread;
  logic [DW-1:0] exp_irdata;
  logic [DW-1:0] exp_drdata;
  logic          last_ig;
  logic          last_dg;
  int            starve;

  logic [DW-1:0] mem [256] = '{default: '0};

  sp_ram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .ram_en_o      (ram_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_we_o      (ram_we_o),
    .ram_be_o      (ram_be_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_i   (ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: read-before-write, one cycle read latency, word index from addr[9:2].
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o[9:2]];
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check last cycle's responses and this cycle's grant, advance the model.
  task automatic applyStimulus(input logic rst_n, input logic ireq, input logic [AW-1:0] iaddr,
                               input logic dreq, input logic dwe, input logic [3:0] dbe,
                               input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata);
    logic eg_i;
    logic eg_d;
    @(negedge clk);
    rstn_i       = rst_n;
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
    #1;
    checkOutput("instr_rvalid", instr_rvalid_o, pend_i && rst_n);
    checkOutput("data_rvalid", data_rvalid_o, pend_d && rst_n);
    if (pend_i && rst_n) checkOutput("instr_rdata", instr_rdata_o, exp_irdata);
    if (pend_d && pend_dread && rst_n) checkOutput("data_rdata", data_rdata_o, exp_drdata);

    eg_i = 1'b0;
    eg_d = 1'b0;
    if (rst_n) begin
      if (ireq && (!dreq || (GUARD && starve >= STALL_MAX))) eg_i = 1'b1;
      else if (dreq) eg_d = 1'b1;
    end
    checkOutput("instr_gnt", instr_gnt_o, eg_i);
    checkOutput("data_gnt", data_gnt_o, eg_d);
    checkOutput("ram_en", ram_en_o, eg_i || eg_d);
    if (eg_d) begin
      checkOutput("ram_addr_d", ram_addr_o, daddr);
      checkOutput("ram_we_d", ram_we_o, dwe);
      checkOutput("ram_be_d", ram_be_o, dbe);
      checkOutput("ram_wdata_d", ram_wdata_o, dwdata);
    end else if (eg_i) begin
      checkOutput("ram_addr_i", ram_addr_o, iaddr);
      checkOutput("ram_we_i", ram_we_o, 1'b0);
      checkOutput("ram_be_i", ram_be_o, 4'hF);
      checkOutput("ram_wdata_i", ram_wdata_o, '0);
    end else begin
      checkOutput("ram_we_idle", ram_we_o, 1'b0);
    end

    if (eg_i) exp_irdata = shadow[iaddr[9:2]];
    if (eg_d) begin
      exp_drdata = shadow[daddr[9:2]];
      if (dwe) begin
        for (int b = 0; b < 4; b++) begin
          if (dbe[b]) shadow[daddr[9:2]][8*b +: 8] = dwdata[8*b +: 8];
        end
      end
    end
    pend_i     = eg_i;
    pend_d     = eg_d;
    pend_dread = !dwe;
    last_ig    = eg_i;
    last_dg    = eg_d;
    if (!rst_n || !ireq || eg_i) starve = 0;
    else starve++;
  endtask

  initial begin
    logic          r_rst;
    logic          r_ireq;
    logic [AW-1:0] r_iaddr;
    logic          r_dreq;
    logic          r_dwe;
    logic [3:0]    r_dbe;
    logic [AW-1:0] r_daddr;
    logic [DW-1:0] r_dwdata;

    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    pend_i = 1'b0; pend_d = 1'b0; pend_dread = 1'b0;
    exp_irdata = '0; exp_drdata = '0;
    last_ig = 1'b0; last_dg = 1'b0; starve = 0;
    rstn_i = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0;
    data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;

    $display("[TB] reset with requests pending");
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);

    $display("[TB] instruction fetch of a preloaded word");
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'hF, 16'h0010, 32'h0000_0013);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);
    checkOutput("fetch_0010_rdata", instr_rdata_o, 32'h0000_0013);

    $display("[TB] partial data write then read back");
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0011, 16'h0020, 32'hAABB_CCDD);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);
    checkOutput("readback_0020", data_rdata_o, 32'h0000_CCDD);

    $display("[TB] both ports requesting continuously");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 4'hF, 16'h0044, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);

    $display("[TB] reset right after a data read grant");
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b1, 1'b1, 4'hF, 16'h0024, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);

    $display("[TB] alternating single-port grants");
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) applyStimulus(1'b1, 1'b1, 16'(k * 4), 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);
      else            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hF, 16'(k * 4), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);

    $display("[TB] randomized traffic");
    r_ireq = 1'b0; r_iaddr = '0; r_dreq = 1'b0; r_dwe = 1'b0;
    r_dbe = '0; r_daddr = '0; r_dwdata = '0;
    for (int n = 0; n < 300; n++) begin
      r_rst = ($urandom_range(0, 39) != 0);
      if (!(r_ireq && !last_ig)) begin
        r_ireq  = 1'($urandom_range(0, 1));
        r_iaddr = 16'($urandom_range(0, 1023));
      end
      if (!(r_dreq && !last_dg)) begin
        r_dreq   = 1'($urandom_range(0, 1));
        r_dwe    = 1'($urandom_range(0, 1));
        r_dbe    = 4'($urandom);
        r_daddr  = 16'($urandom_range(0, 1023));
        r_dwdata = $urandom;
      end
      applyStimulus(r_rst, r_ireq, r_iaddr, r_dreq, r_dwe, r_dbe, r_daddr, r_dwdata);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
